// File: rtl/exec_ctrl_if.sv
// Instruction handshake, ALU operand/result and architectural state
// visible between exec_ctrl and its neighbours.
interface exec_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [2:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_y;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic       zero;
  logic [7:0] out_data;
  logic       out_valid;
  logic       done;
  logic       busy;

  // Instruction source and ALU side
  modport master (
    output instr_valid, instr, alu_y,
    input  instr_ready, alu_op, alu_a, alu_b, reg_a, reg_b,
           zero, out_data, out_valid, done, busy
  );

  // Execute/control stage side
  modport slave (
    input  instr_valid, instr, alu_y,
    output instr_ready, alu_op, alu_a, alu_b, reg_a, reg_b,
           zero, out_data, out_valid, done, busy
  );
endinterface

// File: rtl/exec_ctrl.sv
// Execute/control stage for the 8-bit ALU: fetches one instruction per
// handshake, drives the ALU from the A/B registers and writes the result back.
module exec_ctrl #(
  parameter logic [7:0] RESET_A = 8'h00,
  parameter logic [7:0] RESET_B = 8'h00
) (
  input logic        clk,
  input logic        rst,
  exec_ctrl_if.slave bus
);

  localparam int unsigned DataW = 8;
  localparam int unsigned OpW   = 3;
  localparam int unsigned ImmW  = 4;

  localparam logic [OpW-1:0] OpIdle = 3'b100;
  localparam logic [OpW-1:0] OpLdi  = 3'b110;
  localparam logic [OpW-1:0] OpOut  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic [OpW-1:0]  op;
    logic            dst;
    logic [ImmW-1:0] imm;
  } instr_t;

  state_e           state_q, state_d;
  instr_t           ir_q, ir_d;
  logic [DataW-1:0] reg_a_q, reg_a_d;
  logic [DataW-1:0] reg_b_q, reg_b_d;
  logic             zero_q, zero_d;
  logic [DataW-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             instr_ready_q, instr_ready_d;
  logic             busy_q, busy_d;
  logic [OpW-1:0]   alu_op_q, alu_op_d;

  logic             is_alu_op;
  logic [DataW-1:0] dst_val;
  logic [DataW-1:0] imm_ext;

  // Decode of the held instruction
  always_comb begin
    is_alu_op = !(ir_q.op[2] && ir_q.op[1]);
    dst_val   = ir_q.dst ? reg_b_q : reg_a_q;
    imm_ext   = DataW'({4'h0, ir_q.imm});
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ir_q          <= '0;
      reg_a_q       <= RESET_A;
      reg_b_q       <= RESET_B;
      zero_q        <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      instr_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      alu_op_q      <= OpIdle;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      reg_a_q       <= reg_a_d;
      reg_b_q       <= reg_b_d;
      zero_q        <= zero_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      done_q        <= done_d;
      instr_ready_q <= instr_ready_d;
      busy_q        <= busy_d;
      alu_op_q      <= alu_op_d;
    end
  end

  // Next state, writeback and registered status outputs
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    zero_d      = zero_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          ir_d    = instr_t'(bus.instr);
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = WB;
        done_d  = 1'b1;
        if (is_alu_op) begin
          if (ir_q.dst) reg_b_d = bus.alu_y;
          else          reg_a_d = bus.alu_y;
          zero_d = (bus.alu_y == '0);
        end else if (ir_q.op == OpLdi) begin
          if (ir_q.dst) reg_b_d = imm_ext;
          else          reg_a_d = imm_ext;
        end else begin
          out_data_d  = dst_val;
          out_valid_d = 1'b1;
        end
      end

      WB: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Status outputs follow the state being entered so they stay registered
    instr_ready_d = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    alu_op_d      = OpIdle;
    if (state_d == EXEC && !(ir_d.op[2] && ir_d.op[1])) begin
      alu_op_d = ir_d.op;
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.busy        = busy_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_a       = reg_a_q;
  assign bus.alu_b       = reg_b_q;
  assign bus.reg_a       = reg_a_q;
  assign bus.reg_b       = reg_b_q;
  assign bus.zero        = zero_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.done        = done_q;

  // OpOut is implied by the final else branch above
  logic unused_op_out;
  assign unused_op_out = (ir_q.op == OpOut);

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: models the ALU and the architectural state, queues the
// expected state per instruction and compares it when done pulses.
module tb_exec_ctrl;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       z;
    logic       ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exec_ctrl_if bus ();

  exec_ctrl #(.RESET_A(8'h00), .RESET_B(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALU
  always_comb begin
    bus.alu_y = 8'h00;
    case (bus.alu_op)
      3'b000: bus.alu_y = bus.alu_a + bus.alu_b;
      3'b001: bus.alu_y = bus.alu_a - bus.alu_b;
      3'b010: bus.alu_y = bus.alu_a & bus.alu_b;
      3'b011: bus.alu_y = bus.alu_a | bus.alu_b;
      3'b100: bus.alu_y = bus.alu_a;
      3'b101: bus.alu_y = bus.alu_b;
      default: bus.alu_y = 8'h00;
    endcase
  end

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [7:0] m_a, m_b, m_out;
  logic       m_z;

  function automatic exp_t model_apply(input logic [7:0] ins);
    logic [2:0] op;
    logic [7:0] r, src;
    exp_t       e;
    op  = ins[7:5];
    src = ins[4] ? m_b : m_a;
    r   = 8'h00;
    case (op)
      3'd0: r = 8'(m_a + m_b);
      3'd1: r = 8'(m_a - m_b);
      3'd2: r = m_a & m_b;
      3'd3: r = m_a | m_b;
      3'd4: r = m_a;
      3'd5: r = m_b;
      3'd6: r = {4'h0, ins[3:0]};
      default: r = 8'h00;
    endcase
    if (op == 3'd7) m_out = src;
    else if (ins[4]) m_b = r;
    else m_a = r;
    if (op <= 3'd5) m_z = (r == 8'h00);
    e.a   = m_a;
    e.b   = m_b;
    e.out = m_out;
    e.z   = m_z;
    e.ov  = (op == 3'd7);
    return e;
  endfunction

  // Drive one instruction, return at the negedge where done is seen
  task automatic send(input logic [7:0] ins, output int lat, output int rdy_lo,
                      output logic [2:0] op_exec);
    int guard;
    sb.push_back(model_apply(ins));
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    guard = 0;
    while (!bus.instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    lat     = 1;
    rdy_lo  = 0;
    op_exec = 3'bxxx;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) op_exec = bus.alu_op;
      if (!bus.instr_ready) rdy_lo++;
      if (bus.done) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    m_a = 8'h00; m_b = 8'h00; m_z = 1'b0; m_out = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.reg_a, bus.reg_b, bus.zero, bus.out_data} !== {8'h00, 8'h00, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_regs: got a=%h b=%h z=%b out=%h, want 00 00 0 00",
               bus.reg_a, bus.reg_b, bus.zero, bus.out_data);
    end
    n_chk++;
    if ({bus.instr_ready, bus.busy, bus.done, bus.out_valid, bus.alu_op} !== {4'b1000, 3'b100}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b busy=%b done=%b ov=%b op=%b, want 1 0 0 0 100",
               bus.instr_ready, bus.busy, bus.done, bus.out_valid, bus.alu_op);
    end
  endtask

  task automatic test_load_add();
    logic [7:0] prog [3] = '{8'hC5, 8'hD3, 8'h00};
    int lat, rl;
    logic [2:0] oe;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      send(prog[i], lat, rl, oe);
      e = sb.pop_front();
      n_chk++;
      if ({bus.reg_a, bus.reg_b, bus.zero, bus.out_valid, bus.out_data} !== {e.a, e.b, e.z, e.ov, e.out}) begin
        n_fail++;
        $display("FAIL load_add_%0d: got a=%h b=%h z=%b ov=%b out=%h, want a=%h b=%h z=%b ov=%b out=%h",
                 i, bus.reg_a, bus.reg_b, bus.zero, bus.out_valid, bus.out_data,
                 e.a, e.b, e.z, e.ov, e.out);
      end
      n_chk++;
      if (lat !== 2 || rl !== 2) begin
        n_fail++;
        $display("FAIL load_add_timing_%0d: got latency=%0d ready_low=%0d, want 2 2", i, lat, rl);
      end
    end
    n_chk++;
    if ({bus.reg_a, bus.zero} !== {8'h08, 1'b0}) begin
      n_fail++;
      $display("FAIL add_result: got a=%h z=%b, want 08 0", bus.reg_a, bus.zero);
    end
  endtask

  task automatic test_alu();
    logic [7:0] ops  [5] = '{8'h30, 8'h40, 8'h60, 8'h90, 8'hA0};
    logic [7:0] want [5] = '{8'h02, 8'h01, 8'h07, 8'h05, 8'h03};
    logic [7:0] seq [3];
    logic [7:0] got;
    int lat, rl;
    logic [2:0] oe;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      seq = '{8'hC5, 8'hD3, ops[i]};
      for (int j = 0; j < 3; j++) begin
        send(seq[j], lat, rl, oe);
        e = sb.pop_front();
        n_chk++;
        if ({bus.reg_a, bus.reg_b, bus.zero, bus.out_valid} !== {e.a, e.b, e.z, e.ov}) begin
          n_fail++;
          $display("FAIL alu_sb_%0d_%0d: got a=%h b=%h z=%b ov=%b, want a=%h b=%h z=%b ov=%b",
                   i, j, bus.reg_a, bus.reg_b, bus.zero, bus.out_valid, e.a, e.b, e.z, e.ov);
        end
      end
      got = ops[i][4] ? bus.reg_b : bus.reg_a;
      n_chk++;
      if (got !== want[i]) begin
        n_fail++;
        $display("FAIL alu_result_%h: got %h, want %h", ops[i], got, want[i]);
      end
      n_chk++;
      if (oe !== ops[i][7:5] || bus.alu_op !== 3'b100) begin
        n_fail++;
        $display("FAIL alu_op_%h: got exec=%b wb=%b, want exec=%b wb=100",
                 ops[i], oe, bus.alu_op, ops[i][7:5]);
      end
    end
  endtask

  task automatic test_zero_wrap();
    logic [7:0] seq [4] = '{8'hC3, 8'hD3, 8'h20, 8'hDF};
    int lat, rl;
    logic [2:0] oe;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      send(seq[i], lat, rl, oe);
      e = sb.pop_front();
      n_chk++;
      if ({bus.reg_a, bus.reg_b, bus.zero} !== {e.a, e.b, e.z}) begin
        n_fail++;
        $display("FAIL zero_sb_%0d: got a=%h b=%h z=%b, want a=%h b=%h z=%b",
                 i, bus.reg_a, bus.reg_b, bus.zero, e.a, e.b, e.z);
      end
      if (i == 2 || i == 3) begin
        n_chk++;
        if (bus.zero !== 1'b1) begin
          n_fail++;
          $display("FAIL zero_flag_%0d: got %b, want 1", i, bus.zero);
        end
      end
    end
    send(8'hCF, lat, rl, oe);
    void'(sb.pop_front());
    for (int k = 1; k <= 17; k++) begin
      send(8'h00, lat, rl, oe);
      e = sb.pop_front();
      n_chk++;
      if ({bus.reg_a, bus.zero} !== {e.a, e.z}) begin
        n_fail++;
        $display("FAIL wrap_sb_%0d: got a=%h z=%b, want a=%h z=%b", k, bus.reg_a, bus.zero, e.a, e.z);
      end
      if (k == 16 || k == 17) begin
        n_chk++;
        if (bus.reg_a !== ((k == 16) ? 8'hFF : 8'h0E)) begin
          n_fail++;
          $display("FAIL wrap_const_%0d: got %h, want %h", k, bus.reg_a, (k == 16) ? 8'hFF : 8'h0E);
        end
      end
    end
  endtask

  task automatic test_out();
    int lat, rl;
    logic [2:0] oe;
    exp_t e;
    logic [7:0] a_before;
    send(8'hD3, lat, rl, oe);
    void'(sb.pop_front());
    a_before = bus.reg_a;
    send(8'hF0, lat, rl, oe);
    e = sb.pop_front();
    n_chk++;
    if ({bus.out_valid, bus.out_data, bus.reg_a, bus.reg_b} !== {e.ov, e.out, e.a, e.b}) begin
      n_fail++;
      $display("FAIL out_sb: got ov=%b out=%h a=%h b=%h, want ov=%b out=%h a=%h b=%h",
               bus.out_valid, bus.out_data, bus.reg_a, bus.reg_b, e.ov, e.out, e.a, e.b);
    end
    n_chk++;
    if ({bus.out_valid, bus.out_data, bus.reg_a, bus.reg_b} !== {1'b1, 8'h03, a_before, 8'h03}) begin
      n_fail++;
      $display("FAIL out_b: got ov=%b out=%h a=%h b=%h, want 1 03 %h 03",
               bus.out_valid, bus.out_data, bus.reg_a, bus.reg_b, a_before);
    end
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL out_pulse: got ov=%b done=%b one cycle later, want 0 0", bus.out_valid, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    int done_at [$];
    exp_t e;
    sb.push_back(model_apply(8'hC1));
    sb.push_back(model_apply(8'hD2));
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 8'hC1;
    guard = 0;
    while (!bus.instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 bus.instr = 8'hD2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) bus.instr_valid = 1'b0;
      if (bus.done) begin
        done_at.push_back(i);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_chk++;
          if ({bus.reg_a, bus.reg_b} !== {e.a, e.b}) begin
            n_fail++;
            $display("FAIL b2b_sb_%0d: got a=%h b=%h, want a=%h b=%h", i, bus.reg_a, bus.reg_b, e.a, e.b);
          end
        end
      end
    end
    n_chk++;
    if (done_at.size() != 2 || done_at[0] != 1 || done_at[1] != 4) begin
      n_fail++;
      $display("FAIL b2b_timing: got %0d done pulses, want 2 at cycles 1 and 4", done_at.size());
    end
    n_chk++;
    if ({bus.reg_a, bus.reg_b} !== {8'h01, 8'h02}) begin
      n_fail++;
      $display("FAIL b2b_regs: got a=%h b=%h, want 01 02", bus.reg_a, bus.reg_b);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_op();
    int guard;
    int lat, rl;
    logic [2:0] oe;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 8'hC9;
    guard = 0;
    while (!bus.instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_z = 1'b0; m_out = 8'h00;
    @(negedge clk);
    n_chk++;
    if ({bus.reg_a, bus.done, bus.instr_ready, bus.busy} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid: got a=%h done=%b rdy=%b busy=%b, want 00 0 1 0",
               bus.reg_a, bus.done, bus.instr_ready, bus.busy);
    end
    @(negedge clk);
    n_chk++;
    if (bus.done !== 1'b0 || bus.reg_a !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_late: got done=%b a=%h, want 0 00", bus.done, bus.reg_a);
    end
    send(8'hC4, lat, rl, oe);
    void'(sb.pop_front());
    n_chk++;
    if (bus.reg_a !== 8'h04 || lat !== 2) begin
      n_fail++;
      $display("FAIL rst_recover: got a=%h latency=%0d, want 04 2", bus.reg_a, lat);
    end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_alu();
    test_zero_wrap();
    test_out();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
